// File: rtl/fifo2vga_pkg.sv
// Shared definitions for the SDRAM -> VGA pixel FIFO.
//  - W_* : SDRAM controller work-state codes (W_RDDAT marks read data on the bus)
//  - pix_mode_e : output pixel format selector
//  - pix_format : reformats a 16-bit RGB565 word for the selected mode
package fifo2vga_pkg;

  localparam logic [4:0] W_IDLE  = 5'd0;
  localparam logic [4:0] W_PRECH = 5'd1;
  localparam logic [4:0] W_AREF  = 5'd2;
  localparam logic [4:0] W_MRS   = 5'd3;
  localparam logic [4:0] W_ACT   = 5'd4;
  localparam logic [4:0] W_RD    = 5'd5;
  localparam logic [4:0] W_RDDAT = 5'd6;
  localparam logic [4:0] W_WR    = 5'd7;

  typedef enum logic [1:0] {
    PIX_RAW    = 2'd0,
    PIX_RGB111 = 2'd1,
    PIX_RGB332 = 2'd2
  } pix_mode_e;

  // RGB565 in: R=d[15:11], G=d[10:5], B=d[4:0]. Code 3 falls through to raw.
  function automatic logic [15:0] pix_format(input logic [15:0] d, input logic [1:0] mode);
    logic [15:0] r;
    r = d;
    case (mode)
      PIX_RGB111: r = {13'b0, d[15], d[10], d[4]};
      PIX_RGB332: r = {8'b0, d[15:13], d[10:8], d[4:3]};
      default:    r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sdram_vga_pixfifo_if.sv
// Bus bundle between the SDRAM read side / VGA scan-out and the pixel FIFO.
//  slave  : the FIFO (consumes controller state, data, pop; drives pixel + status)
//  master : the environment driving the FIFO
interface sdram_vga_pixfifo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int ST_W   = 5
);
  logic [ST_W-1:0]   work_st;
  logic [DATA_W-1:0] sdram_data;
  logic              fifo_clear;
  logic [1:0]        pix_mode_i;
  logic              vga_rdfifo;
  logic [DATA_W-1:0] data_vga;
  logic              data_vld_o;
  logic [ADDR_W:0]   fifo_used_o;
  logic              empty_o;
  logic              full_o;
  logic              burst_req_o;
  logic              ovf_o;
  logic              udf_o;

  modport slave (
    input  work_st, sdram_data, fifo_clear, pix_mode_i, vga_rdfifo,
    output data_vga, data_vld_o, fifo_used_o, empty_o, full_o, burst_req_o, ovf_o, udf_o
  );

  modport master (
    output work_st, sdram_data, fifo_clear, pix_mode_i, vga_rdfifo,
    input  data_vga, data_vld_o, fifo_used_o, empty_o, full_o, burst_req_o, ovf_o, udf_o
  );
endinterface

// File: rtl/sdram_vga_pixfifo_sdp_ram.sv
// Simple dual-port RAM, one write port, one synchronous read port.
// Read is read-before-write: a same-address read/write returns the old word,
// which the FIFO relies on for write+pop while full.
//  clk_i, rst_ni     : clock, async active-low reset (clears only the read register)
//  we_i/waddr_i/wdata_i : write port
//  re_i/raddr_i      : read enable/address; rdata_o holds when re_i is low
module sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/sdram_vga_pixfifo.sv
// Pixel FIFO between the SDRAM read engine and VGA scan-out.
//  clk_100M, nrst_i : clock, async active-low reset
//  bus (slave)      : work_st/sdram_data write side, vga_rdfifo pop side,
//                     formatted data_vga + data_vld_o, fill/status flags.
// Words are captured whenever work_st == RDDAT_ST. Pops have one cycle of
// latency; the pixel format is latched with the pop and applied to the RAM
// read register, so data_vga is purely a function of registered state.
module sdram_vga_pixfifo
  import fifo2vga_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int BURST_LEN = 256,
  parameter int ST_W      = 5,
  parameter int RDDAT_ST  = int'(W_RDDAT)
) (
  input  logic           clk_100M,
  input  logic           nrst_i,
  sdram_vga_pixfifo_if.slave bus
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] BURST_TH = (ADDR_W+1)'(DEPTH - BURST_LEN);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, vld_q, vld_d, burst_q;
  logic [1:0]        mode_q, mode_d;
  logic              empty, full, wr, pop_req, wr_ok, pop_ok;
  logic [DATA_W-1:0] ram_q;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);

  always_comb begin
    wr      = (bus.work_st == ST_W'(RDDAT_ST));
    pop_req = bus.vga_rdfifo;
    // No fall-through: a pop on empty never sees the same-cycle write.
    pop_ok  = pop_req && !empty && !bus.fifo_clear;
    // A full FIFO still accepts a write when a pop frees the slot this cycle.
    wr_ok   = wr && (!full || (pop_req && !empty)) && !bus.fifo_clear;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    vld_d    = 1'b0;
    mode_d   = mode_q;

    if (bus.fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        mode_d   = bus.pix_mode_i;
      end
      if (wr_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
      else if (!wr_ok && pop_ok) cnt_d = cnt_q - 1'b1;
      if (wr && !wr_ok)   ovf_d = 1'b1;
      if (pop_req && empty) udf_d = 1'b1;
      vld_d = pop_ok;
    end
  end

  always_ff @(posedge clk_100M or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      vld_q    <= 1'b0;
      mode_q   <= 2'd0;
      burst_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_q    <= vld_d;
      mode_q   <= mode_d;
      burst_q  <= (cnt_d <= BURST_TH);
    end
  end

  sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk_100M),
    .rst_ni  (nrst_i),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.sdram_data),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_q)
  );

  // Formatting only makes sense for RGB565 words; other widths pass raw.
  generate
    if (DATA_W == 16) begin : g_fmt
      assign bus.data_vga = pix_format(ram_q, mode_q);
    end else begin : g_raw
      assign bus.data_vga = ram_q;
    end
  endgenerate

  assign bus.data_vld_o  = vld_q;
  assign bus.fifo_used_o = cnt_q;
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.burst_req_o = burst_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.udf_o       = udf_q;
endmodule

// File: tb/tb_sdram_vga_pixfifo.sv
module tb_sdram_vga_pixfifo;
  logic clk_100M = 1'b0;
  logic nrst_i   = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sdram_vga_pixfifo_if #(.DATA_W(16), .ADDR_W(10), .ST_W(5)) bus ();

  sdram_vga_pixfifo #(.DATA_W(16), .ADDR_W(10), .BURST_LEN(256), .ST_W(5), .RDDAT_ST(6)) dut (
    .clk_100M (clk_100M),
    .nrst_i   (nrst_i),
    .bus      (bus)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic step();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    bus.work_st    = 5'd6;
    bus.sdram_data = d;
    step();
    bus.work_st    = 5'd0;
  endtask

  task automatic pop(input logic [1:0] mode);
    bus.pix_mode_i = mode;
    bus.vga_rdfifo = 1'b1;
    step();
    bus.vga_rdfifo = 1'b0;
  endtask

  task automatic test_reset();
    bus.work_st = 5'd0; bus.sdram_data = '0; bus.fifo_clear = 1'b0;
    bus.pix_mode_i = 2'd0; bus.vga_rdfifo = 1'b0;
    nrst_i = 1'b0;
    step(); step();
    checks++;
    if (bus.fifo_used_o !== 11'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 ||
        bus.ovf_o !== 1'b0 || bus.udf_o !== 1'b0 || bus.data_vld_o !== 1'b0 ||
        bus.data_vga !== 16'h0 || bus.burst_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: used=%0d empty=%b full=%b ovf=%b udf=%b vld=%b data=%h burst=%b",
               bus.fifo_used_o, bus.empty_o, bus.full_o, bus.ovf_o, bus.udf_o,
               bus.data_vld_o, bus.data_vga, bus.burst_req_o);
    end
    nrst_i = 1'b1;
    step();
    checks++;
    if (bus.burst_req_o !== 1'b1) begin
      errors++; $display("FAIL reset_burst_req: got %b want 1", bus.burst_req_o);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) push(16'(i));
    checks++;
    if (bus.fifo_used_o !== 11'd4) begin
      errors++; $display("FAIL basic_used: got %0d want 4", bus.fifo_used_o);
    end
    for (int i = 1; i <= 4; i++) begin
      pop(2'd0);
      checks++;
      if (bus.data_vld_o !== 1'b1 || bus.data_vga !== 16'(i)) begin
        errors++; $display("FAIL basic_pop%0d: vld=%b data=%h want vld=1 data=%h", i, bus.data_vld_o, bus.data_vga, 16'(i));
      end
    end
    step();
    checks++;
    if (bus.data_vld_o !== 1'b0 || bus.empty_o !== 1'b1) begin
      errors++; $display("FAIL basic_idle: vld=%b empty=%b want 0/1", bus.data_vld_o, bus.empty_o);
    end
  endtask

  task automatic test_fill_full();
    int bad;
    for (int i = 0; i < 1024; i++) begin
      push(16'(16'h1000 + i));
      if (i == 767) begin
        checks++;
        if (bus.burst_req_o !== 1'b1 || bus.fifo_used_o !== 11'd768) begin
          errors++; $display("FAIL burst_768: burst=%b used=%0d want 1/768", bus.burst_req_o, bus.fifo_used_o);
        end
      end
      if (i == 768) begin
        checks++;
        if (bus.burst_req_o !== 1'b0 || bus.fifo_used_o !== 11'd769) begin
          errors++; $display("FAIL burst_769: burst=%b used=%0d want 0/769", bus.burst_req_o, bus.fifo_used_o);
        end
      end
    end
    checks++;
    if (bus.fifo_used_o !== 11'd1024 || bus.full_o !== 1'b1 || bus.ovf_o !== 1'b0) begin
      errors++; $display("FAIL full_state: used=%0d full=%b ovf=%b want 1024/1/0", bus.fifo_used_o, bus.full_o, bus.ovf_o);
    end
    push(16'hDEAD);
    checks++;
    if (bus.fifo_used_o !== 11'd1024 || bus.ovf_o !== 1'b1 || bus.full_o !== 1'b1) begin
      errors++; $display("FAIL overflow: used=%0d ovf=%b full=%b want 1024/1/1", bus.fifo_used_o, bus.ovf_o, bus.full_o);
    end
    bus.work_st = 5'd6; bus.sdram_data = 16'hBEEF;
    pop(2'd0);
    bus.work_st = 5'd0;
    checks++;
    if (bus.fifo_used_o !== 11'd1024 || bus.data_vga !== 16'h1000 || bus.data_vld_o !== 1'b1 || bus.ovf_o !== 1'b1) begin
      errors++; $display("FAIL full_wr_pop: used=%0d data=%h vld=%b want 1024/1000/1", bus.fifo_used_o, bus.data_vga, bus.data_vld_o);
    end
    bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      logic [15:0] exp;
      exp = (i == 1024) ? 16'hBEEF : 16'(16'h1000 + i);
      pop(2'd0);
      if (bus.data_vga !== exp || bus.data_vld_o !== 1'b1) begin
        if (bad == 0) $display("FAIL drain_order: at %0d got %h want %h", i, bus.data_vga, exp);
        bad++;
      end
    end
    checks++;
    if (bad != 0 || bus.empty_o !== 1'b1) begin
      errors++; $display("FAIL drain: bad=%0d empty=%b want 0/1", bad, bus.empty_o);
    end
  endtask

  task automatic test_underflow();
    pop(2'd0);
    checks++;
    if (bus.udf_o !== 1'b1 || bus.data_vld_o !== 1'b0 || bus.data_vga !== 16'hBEEF || bus.fifo_used_o !== 11'd0) begin
      errors++; $display("FAIL udf_empty_pop: udf=%b vld=%b data=%h used=%0d want 1/0/beef/0",
                         bus.udf_o, bus.data_vld_o, bus.data_vga, bus.fifo_used_o);
    end
    bus.work_st = 5'd6; bus.sdram_data = 16'h1234;
    pop(2'd0);
    bus.work_st = 5'd0;
    checks++;
    if (bus.fifo_used_o !== 11'd1 || bus.udf_o !== 1'b1 || bus.data_vld_o !== 1'b0 || bus.data_vga !== 16'hBEEF) begin
      errors++; $display("FAIL udf_wr_pop_empty: used=%0d udf=%b vld=%b data=%h want 1/1/0/beef",
                         bus.fifo_used_o, bus.udf_o, bus.data_vld_o, bus.data_vga);
    end
    pop(2'd0);
    checks++;
    if (bus.data_vga !== 16'h1234 || bus.data_vld_o !== 1'b1 || bus.empty_o !== 1'b1) begin
      errors++; $display("FAIL udf_followup: data=%h vld=%b empty=%b want 1234/1/1", bus.data_vga, bus.data_vld_o, bus.empty_o);
    end
  endtask

  task automatic test_format();
    push(16'hF800); push(16'h07E0); push(16'hABCD);
    pop(2'd1);
    checks++;
    if (bus.data_vga !== 16'h0004) begin
      errors++; $display("FAIL fmt_rgb111: got %h want 0004", bus.data_vga);
    end
    pop(2'd2);
    checks++;
    if (bus.data_vga !== 16'h001C) begin
      errors++; $display("FAIL fmt_rgb332: got %h want 001c", bus.data_vga);
    end
    pop(2'd0);
    checks++;
    if (bus.data_vga !== 16'hABCD) begin
      errors++; $display("FAIL fmt_raw: got %h want abcd", bus.data_vga);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 500; i++) push(16'(16'h2000 + i));
    checks++;
    if (bus.fifo_used_o !== 11'd500 || bus.ovf_o !== 1'b1 || bus.udf_o !== 1'b1) begin
      errors++; $display("FAIL clear_pre: used=%0d ovf=%b udf=%b want 500/1/1", bus.fifo_used_o, bus.ovf_o, bus.udf_o);
    end
    bus.fifo_clear = 1'b1; bus.work_st = 5'd6; bus.sdram_data = 16'h5555;
    pop(2'd0);
    bus.fifo_clear = 1'b0; bus.work_st = 5'd0;
    checks++;
    if (bus.fifo_used_o !== 11'd0 || bus.ovf_o !== 1'b0 || bus.udf_o !== 1'b0 || bus.data_vld_o !== 1'b0 ||
        bus.empty_o !== 1'b1 || bus.burst_req_o !== 1'b1 || bus.data_vga !== 16'hABCD) begin
      errors++; $display("FAIL clear: used=%0d ovf=%b udf=%b vld=%b empty=%b burst=%b data=%h want 0/0/0/0/1/1/abcd",
                         bus.fifo_used_o, bus.ovf_o, bus.udf_o, bus.data_vld_o, bus.empty_o, bus.burst_req_o, bus.data_vga);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 5; i++) push(16'(16'h3000 + i));
    bus.work_st = 5'd6; bus.sdram_data = 16'h3005;
    pop(2'd0);
    step(); step();
    nrst_i = 1'b0;
    #2;
    checks++;
    if (bus.fifo_used_o !== 11'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 || bus.ovf_o !== 1'b0 ||
        bus.udf_o !== 1'b0 || bus.data_vld_o !== 1'b0 || bus.data_vga !== 16'h0 || bus.burst_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_burst: used=%0d empty=%b full=%b ovf=%b udf=%b vld=%b data=%h burst=%b",
                         bus.fifo_used_o, bus.empty_o, bus.full_o, bus.ovf_o, bus.udf_o,
                         bus.data_vld_o, bus.data_vga, bus.burst_req_o);
    end
    bus.work_st = 5'd0;
    step();
    nrst_i = 1'b1;
    step();
    checks++;
    if (bus.fifo_used_o !== 11'd0 || bus.burst_req_o !== 1'b1) begin
      errors++; $display("FAIL reset_release: used=%0d burst=%b want 0/1", bus.fifo_used_o, bus.burst_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_full();
    test_underflow();
    test_format();
    test_clear();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
